// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types and constants for the AES state I/O block.
//                Provides the default block width, a 128-bit block type,
//                the state-I/O FSM encoding and the cipher mode codes.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_io_fsm_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/aes_state_io_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : beat_counter
//  Description : Modulo-MAX beat counter shared by the load and drain phases.
//                Wraps to zero on the increment that occurs at MAX-1.
//  Ports       : clk, rst_n  - clock / asynchronous active-low reset
//                inc         - count one beat
//                clr         - synchronous clear (wins over inc)
//                last        - count is at MAX-1
//                zero        - count is at 0 (first beat of a block)
//  Revision    : 1.0  initial release
// ============================================================================
module beat_counter #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic last,
    output logic zero
);

    // A single-beat block still needs one register bit.
    localparam int c_cnt_w = (MAX > 1) ? $clog2(MAX) : 1;

    logic [c_cnt_w-1:0] r_cnt;

    assign last = (r_cnt == c_cnt_w'(MAX - 1));
    assign zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_state_io.sv
`default_nettype none
// ============================================================================
//  Module      : aes_state_io
//  Description : Collects one BLOCK_W-bit block from a BUS_W-wide valid/ready
//                stream, holds it for the AES round engine (which may
//                overwrite it via wen/dnext), then streams it back out
//                MSB-first on done and rearms for the next block.
//  Ports       : clk, rst_n              - clock / async active-low reset
//                abort                   - synchronous clear back to LOAD
//                mode                    - cipher mode, sampled on first beat
//                in_data/in_valid/in_ready    - input beat stream
//                state/state_valid/mode_q     - block register to the engine
//                wen/dnext/done               - engine write-back and finish
//                out_data/out_valid/out_ready - output beat stream
//  Revision    : 1.0  initial release
// ============================================================================
module aes_state_io
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int BUS_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               mode,
    input  logic [BUS_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] state,
    output logic               state_valid,
    output logic               mode_q,
    input  logic               wen,
    input  logic [BLOCK_W-1:0] dnext,
    input  logic               done,
    output logic [BUS_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int BEATS = BLOCK_W / BUS_W;

    generate
        if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32 || BUS_W == 64 ||
              BUS_W == 128) || (BLOCK_W % BUS_W) != 0) begin : g_bad_bus_w
            $error("aes_state_io: BUS_W must be 8/16/32/64/128 and divide BLOCK_W");
        end
    endgenerate

    state_io_fsm_e      r_fsm;
    state_io_fsm_e      w_fsm_nxt;
    logic [BLOCK_W-1:0] r_state;
    logic               r_mode_q;
    logic [BLOCK_W-1:0] w_load_shift;
    logic [BLOCK_W-1:0] w_drain_shift;
    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic               w_zero;

    // Handshake outputs decode only from the FSM state, so neither in_valid
    // nor out_ready has a combinational path to any output.
    assign in_ready    = (r_fsm == LOAD);
    assign state_valid = (r_fsm == HOLD);
    assign out_valid   = (r_fsm == DRAIN);
    assign state       = r_state;
    assign mode_q      = r_mode_q;
    assign out_data    = r_state[BLOCK_W-1 -: BUS_W];

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;

    // Beats enter at the LSB end and leave from the MSB end; a one-beat
    // block replaces the whole register.
    generate
        if (BUS_W == BLOCK_W) begin : g_single_beat
            assign w_load_shift  = in_data;
            assign w_drain_shift = '0;
        end else begin : g_multi_beat
            assign w_load_shift  = {r_state[BLOCK_W-BUS_W-1:0], in_data};
            assign w_drain_shift = {r_state[BLOCK_W-BUS_W-1:0], {BUS_W{1'b0}}};
        end
    endgenerate

    // The counter is idle in HOLD, so clearing it there resets it between
    // the load and drain phases.
    beat_counter #(
        .MAX (BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_accept || w_xfer),
        .clr   (abort || (r_fsm == HOLD)),
        .last  (w_last),
        .zero  (w_zero)
    );

    always_comb begin
        w_fsm_nxt = r_fsm;
        if (abort) begin
            w_fsm_nxt = LOAD;
        end else begin
            case (r_fsm)
                LOAD:    if (w_accept && w_last) w_fsm_nxt = HOLD;
                HOLD:    if (done)               w_fsm_nxt = DRAIN;
                DRAIN:   if (w_xfer && w_last)   w_fsm_nxt = LOAD;
                default: w_fsm_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= LOAD;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_mode_q <= MODE_ENC;
        end else if (abort) begin
            r_state  <= '0;
            r_mode_q <= MODE_ENC;
        end else begin
            case (r_fsm)
                LOAD: begin
                    if (w_accept) begin
                        r_state <= w_load_shift;
                        if (w_zero) begin
                            r_mode_q <= mode;
                        end
                    end
                end
                HOLD: begin
                    if (wen) begin
                        r_state <= dnext;
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        r_state <= w_drain_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_state_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_state_io
//  Description : Directed self-checking bench for aes_state_io with byte,
//                word and full-block bus widths.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_state_io;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // BUS_W = 8 instance
    logic         abort8 = 0, mode8 = 0, iv8 = 0, wen8 = 0, done8 = 0, ordy8 = 0;
    logic [7:0]   id8 = '0;
    logic [127:0] dn8 = '0;
    logic         ir8, sv8, mq8, ov8;
    logic [127:0] st8;
    logic [7:0]   od8;

    // BUS_W = 32 instance
    logic         abort32 = 0, mode32 = 0, iv32 = 0, wen32 = 0, done32 = 0, ordy32 = 0;
    logic [31:0]  id32 = '0;
    logic [127:0] dn32 = '0;
    logic         ir32, sv32, mq32, ov32;
    logic [127:0] st32;
    logic [31:0]  od32;

    // BUS_W = 128 instance
    logic         abort128 = 0, mode128 = 0, iv128 = 0, wen128 = 0, done128 = 0, ordy128 = 0;
    logic [127:0] id128 = '0;
    logic [127:0] dn128 = '0;
    logic         ir128, sv128, mq128, ov128;
    logic [127:0] st128;
    logic [127:0] od128;

    aes_state_io #(.BLOCK_W(128), .BUS_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .abort(abort8), .mode(mode8),
        .in_data(id8), .in_valid(iv8), .in_ready(ir8),
        .state(st8), .state_valid(sv8), .mode_q(mq8),
        .wen(wen8), .dnext(dn8), .done(done8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8)
    );

    aes_state_io #(.BLOCK_W(128), .BUS_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .abort(abort32), .mode(mode32),
        .in_data(id32), .in_valid(iv32), .in_ready(ir32),
        .state(st32), .state_valid(sv32), .mode_q(mq32),
        .wen(wen32), .dnext(dn32), .done(done32),
        .out_data(od32), .out_valid(ov32), .out_ready(ordy32)
    );

    aes_state_io #(.BLOCK_W(128), .BUS_W(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .abort(abort128), .mode(mode128),
        .in_data(id128), .in_valid(iv128), .in_ready(ir128),
        .state(st128), .state_valid(sv128), .mode_q(mq128),
        .wen(wen128), .dnext(dn128), .done(done128),
        .out_data(od128), .out_valid(ov128), .out_ready(ordy128)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_W = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [127:0] BLK_C = 128'hffeeddccbbaa99887766554433221100;

    logic [127:0] exp_blk;

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready8", ir8, 1);
        check("rst_state8", st8, 0);
        check("rst_state_valid8", sv8, 0);
        check("rst_out_valid8", ov8, 0);
        check("rst_mode_q8", mq8, 0);
        check("rst_in_ready32", ir32, 1);
        check("rst_in_ready128", ir128, 1);
        rst_n = 1'b1;
        tick();

        // ---- 8-bit load, with wen/done strobes in LOAD after 5 bytes ----
        for (int i = 0; i < 5; i++) begin
            id8 = 8'(i * 17);
            iv8 = 1;
            tick();
        end
        iv8 = 0; wen8 = 1; done8 = 1; dn8 = '1;
        tick();
        wen8 = 0; done8 = 0;
        check("load_ignore_wen_state", st8, 128'h0011223344);
        check("load_ignore_done_ready", ir8, 1);
        check("load_ignore_done_sv", sv8, 0);
        for (int i = 5; i < 16; i++) begin
            id8 = 8'(i * 17);
            iv8 = 1;
            tick();
            if (i == 14) check("sv_low_before_last", sv8, 0);
        end
        check("load8_state", st8, BLK_A);
        check("load8_state_valid", sv8, 1);
        check("load8_in_ready", ir8, 0);
        // in_valid still high while holding: must be ignored
        id8 = 8'h5e;
        tick();
        iv8 = 0;
        check("hold_ignore_in_valid", st8, BLK_A);

        // ---- wen + done together, stalled drain ----
        wen8 = 1; dn8 = BLK_W; done8 = 1;
        tick();
        wen8 = 0; done8 = 0;
        check("drain_first_valid", ov8, 1);
        check("drain_first_byte", od8, 8'h69);
        check("drain_sv_low", sv8, 0);
        for (int k = 0; k < 16; k++) begin
            ordy8 = 0;
            tick();
            exp_blk = BLK_W;
            check($sformatf("drain_beat%0d", k), od8, exp_blk[127 - 8*k -: 8]);
            ordy8 = 1;
            tick();
        end
        ordy8 = 0;
        check("drain_end_out_valid", ov8, 0);
        check("drain_end_in_ready", ir8, 1);
        check("drain_end_state", st8, 0);

        // ---- abort at drain beat 7 ----
        for (int i = 0; i < 16; i++) begin
            id8 = 8'(8'ha0 + i);
            mode8 = (i == 0);
            iv8 = 1;
            tick();
        end
        iv8 = 0; mode8 = 0;
        check("blkB_state", st8, BLK_B);
        check("blkB_mode_q", mq8, 1);
        done8 = 1;
        tick();
        done8 = 0;
        ordy8 = 1;
        repeat (7) tick();
        ordy8 = 0;
        check("abort_pre_byte", od8, 8'ha7);
        abort8 = 1; ordy8 = 1;
        tick();
        abort8 = 0; ordy8 = 0;
        check("abort_out_valid", ov8, 0);
        check("abort_in_ready", ir8, 1);
        check("abort_state", st8, 0);
        check("abort_mode_q", mq8, 0);
        for (int i = 0; i < 16; i++) begin
            id8 = 8'(255 - i * 17);
            iv8 = 1;
            tick();
        end
        iv8 = 0;
        check("post_abort_state", st8, BLK_C);
        check("post_abort_sv", sv8, 1);

        // ---- 32-bit load with gaps, mode only on first beat ----
        for (int i = 0; i < 4; i++) begin
            exp_blk = BLK_A;
            id32 = exp_blk[127 - 32*i -: 32];
            mode32 = (i == 0);
            iv32 = 1;
            tick();
            iv32 = 0;
            mode32 = 0;
            tick();
        end
        check("load32_state", st32, BLK_A);
        check("load32_mode_q", mq32, 1);
        check("load32_sv", sv32, 1);
        done32 = 1;
        tick();
        done32 = 0;
        check("drain32_first", od32, 32'h00112233);

        // ---- async reset mid-load ----
        abort8 = 1;
        tick();
        abort8 = 0;
        for (int i = 0; i < 3; i++) begin
            id8 = 8'(8'h31 + i);
            mode8 = 1;
            iv8 = 1;
            tick();
        end
        iv8 = 0; mode8 = 0;
        check("midload_state", st8, 128'h313233);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state8", st8, 0);
        check("arst_mode_q8", mq8, 0);
        check("arst_in_ready8", ir8, 1);
        check("arst_out_valid32", ov32, 0);
        check("arst_in_ready32", ir32, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- 128-bit single-beat block ----
        id128 = BLK_W; iv128 = 1;
        tick();
        iv128 = 0;
        check("w128_sv", sv128, 1);
        check("w128_state", st128, BLK_W);
        check("w128_in_ready", ir128, 0);
        done128 = 1;
        tick();
        done128 = 0;
        check("w128_out_valid", ov128, 1);
        check("w128_out_data", od128, BLK_W);
        ordy128 = 1;
        tick();
        ordy128 = 0;
        check("w128_end_out_valid", ov128, 0);
        check("w128_end_in_ready", ir128, 1);
        check("w128_end_state", st128, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
